// File: rtl/ni_fifo_param.sv
// ni_fifo_param: parameterised sync FIFO with registered flags/count.
// Define NI_FIFO_FWFT_EN for first-word-fall-through read data.
module ni_fifo_param #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_nxt;
  logic [AW:0]       rd_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              full_nxt;
  logic              empty_nxt;
  logic [DATA_W-1:0] head;

  assign push_ok = write_en & ~full;
  assign pop_ok  = read_en & ~empty;

  assign wr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop_ok};

  // Extra pointer MSB separates a full lap from an empty FIFO
  assign cnt_nxt   = wr_nxt - rd_nxt;
  assign empty_nxt = (wr_nxt == rd_nxt);
  assign full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) &&
                     (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      count        <= cnt_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      overflow     <= write_en & full;
      underflow    <= read_en & empty;
    end
  end

`ifdef NI_FIFO_FWFT_EN
  assign data_out = empty ? '0 : head;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= '0;
    end else if (pop_ok) begin
      data_out <= head;
    end
  end
`endif

endmodule

// File: tb/tb_ni_fifo_param.sv
// tb_ni_fifo_param: table vectors, directed scenarios and random
// traffic against a queue model; mode follows NI_FIFO_FWFT_EN.
module tb_ni_fifo_param;

  localparam int DW    = 64;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [5:0]    count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  typedef struct {
    logic          r;
    logic          we;
    logic          re;
    logic [DW-1:0] din;
    int            cnt;
    logic          ovf;
    logic          udf;
    logic          emp;
    logic [DW-1:0] dstd;
    logic [DW-1:0] dfwft;
  } vec_t;

  vec_t tv[8];

  ni_fifo_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .reset(reset),
    .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_dout();
`ifdef NI_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  // Drive one cycle, advance the model, compare every output
  task automatic step(input logic r, input logic we,
                      input logic re, input logic [DW-1:0] din);
    int n;
    reset    = r;
    write_en = we;
    read_en  = re;
    data_in  = din;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      n     = q.size();
      m_ovf = we && (n == DEPTH);
      m_udf = re && (n == 0);
      if (re && n > 0) m_dout = q.pop_front();
      if (we && n < DEPTH) q.push_back(din);
    end
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
    chk("almost_empty", 64'(almost_empty), 64'(q.size() <= AE));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
    chk("data_out", data_out, exp_dout());
  endtask

  initial begin
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;

    tv[0] = '{1'b0, 1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0, 1'b1,
              64'h0, 64'h0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, 1, 1'b0, 1'b1,
              1'b0, 64'h0, 64'hA5A5A5A5A5A5A5A5};
    tv[2] = '{1'b1, 1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0, 1'b0,
              64'h0, 64'hA5A5A5A5A5A5A5A5};
    tv[3] = '{1'b1, 1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0, 1'b1,
              64'hA5A5A5A5A5A5A5A5, 64'h0};
    tv[4] = '{1'b1, 1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b1, 1'b1,
              64'hA5A5A5A5A5A5A5A5, 64'h0};
    tv[5] = '{1'b1, 1'b1, 1'b0, 64'h1234, 1, 1'b0, 1'b0, 1'b0,
              64'hA5A5A5A5A5A5A5A5, 64'h1234};
    tv[6] = '{1'b1, 1'b1, 1'b1, 64'h5678, 1, 1'b0, 1'b0, 1'b0,
              64'h1234, 64'h5678};
    tv[7] = '{1'b1, 1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0, 1'b1,
              64'h5678, 64'h0};

    // Underflow / simultaneous ops on empty
    for (int i = 0; i < 8; i++) begin
      step(tv[i].r, tv[i].we, tv[i].re, tv[i].din);
      chk("tv_count", 64'(count), 64'(tv[i].cnt));
      chk("tv_ovf", 64'(overflow), 64'(tv[i].ovf));
      chk("tv_udf", 64'(underflow), 64'(tv[i].udf));
      chk("tv_empty", 64'(empty), 64'(tv[i].emp));
`ifdef NI_FIFO_FWFT_EN
      chk("tv_dout", data_out, tv[i].dfwft);
`else
      chk("tv_dout", data_out, tv[i].dstd);
`endif
    end

    // Fill and drain
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'(i));
      chk("fill_af", 64'(almost_full), 64'((i + 1) >= AF));
      chk("fill_full", 64'(full), 64'((i + 1) == DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) begin
`ifdef NI_FIFO_FWFT_EN
      chk("fwft_head", data_out, 64'(i));
`endif
      step(1'b1, 1'b0, 1'b1, '0);
`ifndef NI_FIFO_FWFT_EN
      chk("std_pop", data_out, 64'(i));
`endif
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Overflow
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 64'(100 + i));
    step(1'b1, 1'b1, 1'b0, 64'hDEAD);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'(DEPTH));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("ovf_clear", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef NI_FIFO_FWFT_EN
      chk("ovf_order", data_out, 64'(100 + i));
`endif
      step(1'b1, 1'b0, 1'b1, '0);
`ifndef NI_FIFO_FWFT_EN
      chk("ovf_order", data_out, 64'(100 + i));
`endif
    end

    // Wrap and concurrency
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 64'(200 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, '0);
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 1'b1, 1'b1, 64'(1000 + k));
      chk("wrap_count", 64'(count), 64'd1);
`ifdef NI_FIFO_FWFT_EN
      chk("wrap_seq", data_out, 64'(1000 + k));
`else
      if (k > 0) chk("wrap_seq", data_out, 64'(1000 + k - 1));
`endif
    end

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 64'(300 + i));
    step(1'b0, 1'b1, 1'b1, 64'd77);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_dout", data_out, 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'h35A5A5A5A5A5A5A5);
`ifdef NI_FIFO_FWFT_EN
    chk("rst_push_pop", data_out, 64'h35A5A5A5A5A5A5A5);
`endif
    step(1'b1, 1'b0, 1'b1, '0);
`ifndef NI_FIFO_FWFT_EN
    chk("rst_push_pop", data_out, 64'h35A5A5A5A5A5A5A5);
`endif
    chk("rst_end_empty", 64'(empty), 64'd1);

    // Random traffic with phase-varying bias
    for (int i = 0; i < 800; i++) begin
      int wb;
      logic r;
      logic we;
      logic re;
      wb = ((i / 100) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 99) != 0);
      we = ($urandom_range(0, 99) < wb);
      re = ($urandom_range(0, 99) < (100 - wb));
      step(r, we, re, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_fifo_param.md
NI_FIFO_PARAM -- requirements
Module: ni_fifo_param

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 64, flit width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 32, number of entries; it must be a power of two and at least 2.
REQ-003 The block SHALL provide parameter AF_LEVEL, default DEPTH-2, almost_full threshold as an occupancy count.
REQ-004 The block SHALL provide parameter AE_LEVEL, default 2, almost_empty threshold as an occupancy count.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- write_en  input  1  push request.
- read_en  input  1  pop request.
- data_in  input  DATA_W  push data.
- data_out  output  DATA_W  read data.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- almost_full  output  1  occupancy >= AF_LEVEL.
- almost_empty  output  1  occupancy <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- overflow  output  1  one-cycle pulse when a push is rejected.
- underflow  output  1  one-cycle pulse when a pop is rejected.

Function
REQ-006 The block SHALL accept a push iff write_en=1 and full=0, whatever read_en is; it SHALL write data_in at the write pointer and advance the pointer.
REQ-007 The block SHALL accept a pop iff read_en=1 and empty=0; it SHALL advance the read pointer.
REQ-008 Read and write pointers SHALL wrap modulo DEPTH, and an extra MSB SHALL distinguish full from empty.
REQ-009 On each edge, count SHALL change by +1 for push only, -1 for pop only, and 0 when both or neither are accepted.
REQ-010 full, empty, almost_full, almost_empty and count SHALL be registered and valid in the cycle after the edge that changes occupancy.
REQ-011 Simultaneous push and pop when full: the pop SHALL be accepted, the push SHALL be rejected, count SHALL become DEPTH-1, and overflow SHALL pulse.
REQ-012 Simultaneous push and pop when empty: the push SHALL be accepted, the pop SHALL be rejected, count SHALL become 1, and underflow SHALL pulse.
REQ-013 overflow SHALL be 1 for exactly the cycle after an edge where write_en=1 and full=1; otherwise it SHALL be 0.
REQ-014 underflow SHALL be 1 for exactly the cycle after an edge where read_en=1 and empty=1; otherwise it SHALL be 0.
REQ-015 Rejected operations SHALL NOT modify the pointers, the storage or data_out.
REQ-016 Data SHALL leave the block in strict arrival order, and no entry SHALL be lost or duplicated across pointer wrap.

Reset
REQ-017 While reset=0 at a rising edge, the block SHALL set both pointers to 0 and data_out to 0.
REQ-018 While reset=0 at a rising edge, the block SHALL drive count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-019 Reset asserted mid-operation SHALL discard all stored entries, and any write_en or read_en on that edge SHALL be ignored.
REQ-020 Storage array contents SHALL NOT require reset.

Configuration
REQ-021 Without macro NI_FIFO_FWFT_EN (standard mode), an accepted pop SHALL load the head entry into data_out on that edge (one-cycle read latency), and data_out SHALL hold its value otherwise.
REQ-022 With NI_FIFO_FWFT_EN defined (first-word-fall-through mode), data_out SHALL present the head entry whenever empty=0, with zero pop latency; an accepted pop SHALL expose the next entry in the following cycle.
REQ-023 With NI_FIFO_FWFT_EN defined, data_out SHALL be 0 while empty=1.
REQ-024 All flag and count behaviour SHALL be identical in both modes.

Verification
REQ-025 The bench SHALL cover fill and drain: with DEPTH=32 after reset, push 32 words 0..31, then pop 32; it SHALL check full=1 at count=32, almost_full=1 from count=30, and output order 0..31, ending with empty=1.
REQ-026 The bench SHALL cover overflow: with the FIFO full, push 0xDEAD; it SHALL check overflow pulses once, count stays 32, and 0xDEAD is never read out.
REQ-027 The bench SHALL cover underflow and simultaneous operations on empty: after reset, assert read_en and write_en together with 0xA5A5A5A5A5A5A5A5; it SHALL check underflow pulses, count=1, and the next pop returns 0xA5A5A5A5A5A5A5A5.
REQ-028 The bench SHALL cover wrap and concurrency: push 20, pop 20, then push and pop every cycle for 50 cycles with incrementing data; it SHALL check count stays constant and the sequence is gap-free across the wrap.
REQ-029 The bench SHALL cover reset mid-stream: push 5 words, assert reset=0 for one edge; it SHALL check count=0, empty=1 and data_out=0, and that a following push/pop of 0x35A5A5A5A5A5A5A5 returns that value.
REQ-030 The bench SHALL run scenarios REQ-025 to REQ-029 in both standard and NI_FIFO_FWFT_EN builds, checking 1-cycle and 0-cycle pop-to-data latency respectively.
